bcd_stopwatch_ctrl: RTL and testbench

- Run/pause/clear controller for a chain of cascaded mod-10 (BCD) digit counters.
- A prescaler generates count ticks. The block sequences carry ripple across the digits and handles terminal count as either wrap or saturate-and-halt.
- It also provides a lap-freeze display path.
- Sits between front-panel/debounced control pulses and the BCD-to-7-segment display driver.

---
 rtl/bcd_stopwatch_ctrl.sv | 118 +++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller over cascaded BCD digits with a tick prescaler,
// single-cycle carry ripple, wrap-or-saturate terminal count and a lap-freeze display path.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic                  wrap_en,
  output logic [4*DIGITS-1:0]   bcd_live,
  output logic [4*DIGITS-1:0]   bcd_disp,
  output logic                  running,
  output logic                  lap_held,
  output logic                  ovf,
  output logic                  tick
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int            W         = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [W-1:0]  live, snap, live_inc;
  logic          held, ovf_q, tick_q;
  logic          inc, all9, carry;

  // Every digit sees the pre-edge value of all lower digits, so the whole
  // carry chain resolves in the same cycle as the increment.
  always_comb begin
    inc      = (state == RUN) && !clear && !stop && (presc == PRESC_MAX);
    carry    = 1'b1;
    live_inc = live;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        live_inc[4*k +: 4] = (live[4*k +: 4] == 4'd9) ? 4'd0 : live[4*k +: 4] + 4'd1;
      end
      carry = carry && (live[4*k +: 4] == 4'd9);
    end
    all9 = carry;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !stop) state_nxt = RUN;
        RUN: begin
          if (stop)                           state_nxt = PAUSE;
          else if (inc && all9 && !wrap_en)   state_nxt = DONE;
        end
        PAUSE:   if (start && !stop) state_nxt = RUN;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc  <= '0;
      live   <= '0;
      snap   <= '0;
      held   <= 1'b0;
      ovf_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (clear) begin
      presc  <= '0;
      live   <= '0;
      snap   <= '0;
      held   <= 1'b0;
      ovf_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (state == RUN && !stop) begin
        presc <= inc ? '0 : presc + PRESC_ONE;
      end
      if (inc) begin
        ovf_q <= ovf_q | all9;
        // Saturating terminal count leaves the digits at all 9s and emits no tick.
        if (!(all9 && !wrap_en)) begin
          live   <= live_inc;
          tick_q <= 1'b1;
        end
      end
      if (lap && (state == RUN || state == PAUSE)) begin
        if (!held) snap <= live;
        held <= !held;
      end
    end
  end

  assign bcd_live = live;
  assign bcd_disp = held ? snap : live;
  assign running  = (state == RUN);
  assign lap_held = held;
  assign ovf      = ovf_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench: stimulus queues expected tick values and probe snapshots,
// a single negedge monitor pops and compares them against both DUT instances.
module tb_bcd_stopwatch_ctrl;

  typedef struct packed {
    logic [15:0] live;
    logic [15:0] disp;
    logic        running;
    logic        lap_held;
    logic        ovf;
    logic        tick;
  } obs_t;

  logic clk;
  logic reset_n;
  logic start, stop, clear, lap, wrap_en;
  logic f_start, f_stop, f_clear, f_lap, f_wrap;
  logic [15:0] m_live, m_disp, f_live, f_disp;
  logic m_run, m_held, m_ovf, m_tick;
  logic f_run, f_held, f_ovf, f_tick;

  obs_t        probe_q[$];
  string       name_q[$];
  logic [16:0] tick_q[$];
  logic [16:0] ftick_q[$];
  logic        probe, probe_sel, done, final_checked;
  int          checks, errors;

  obs_t        got_o, exp_o;
  logic [16:0] exp_t;
  string       nm;

  bcd_stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .wrap_en(wrap_en), .bcd_live(m_live), .bcd_disp(m_disp),
    .running(m_run), .lap_held(m_held), .ovf(m_ovf), .tick(m_tick)
  );

  bcd_stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .start(f_start), .stop(f_stop), .clear(f_clear),
    .lap(f_lap), .wrap_en(f_wrap), .bcd_live(f_live), .bcd_disp(f_disp),
    .running(f_run), .lap_held(f_held), .ovf(f_ovf), .tick(f_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    r = '0;
    v = n;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic obs_t mk(input logic [15:0] l, input logic [15:0] d,
                              input logic r, input logic h, input logic o, input logic t);
    obs_t x;
    x.live = l; x.disp = d; x.running = r; x.lap_held = h; x.ovf = o; x.tick = t;
    return x;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic sel, input obs_t e);
    probe_q.push_back(e);
    name_q.push_back(name);
    probe_sel = sel;
    probe     = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic push_ticks(input logic fast, input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      if (fast) ftick_q.push_back({1'b0, to_bcd(n)});
      else      tick_q.push_back({1'b0, to_bcd(n)});
    end
  endtask

  // Monitor: the only process that steps the check/error counters.
  always @(negedge clk) begin
    if (m_tick) begin
      checks++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL main_tick_unexpected got=%h required=none", {m_ovf, m_live});
      end else begin
        exp_t = tick_q.pop_front();
        if ({m_ovf, m_live} !== exp_t) begin
          errors++;
          $display("FAIL main_tick got=%h required=%h", {m_ovf, m_live}, exp_t);
        end
      end
    end
    if (f_tick) begin
      checks++;
      if (ftick_q.size() == 0) begin
        errors++;
        $display("FAIL fast_tick_unexpected got=%h required=none", {f_ovf, f_live});
      end else begin
        exp_t = ftick_q.pop_front();
        if ({f_ovf, f_live} !== exp_t) begin
          errors++;
          $display("FAIL fast_tick got=%h required=%h", {f_ovf, f_live}, exp_t);
        end
      end
    end
    if (probe && probe_q.size() != 0) begin
      exp_o = probe_q.pop_front();
      nm    = name_q.pop_front();
      got_o = probe_sel ? mk(f_live, f_disp, f_run, f_held, f_ovf, f_tick)
                        : mk(m_live, m_disp, m_run, m_held, m_ovf, m_tick);
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL %s got live=%h disp=%h run=%b held=%b ovf=%b tick=%b required live=%h disp=%h run=%b held=%b ovf=%b tick=%b",
                 nm, got_o.live, got_o.disp, got_o.running, got_o.lap_held, got_o.ovf, got_o.tick,
                 exp_o.live, exp_o.disp, exp_o.running, exp_o.lap_held, exp_o.ovf, exp_o.tick);
      end
    end
    if (done && !final_checked) begin
      final_checked = 1'b1;
      checks++;
      if (tick_q.size() != 0 || ftick_q.size() != 0 || probe_q.size() != 0) begin
        errors++;
        $display("FAIL queues_drained got main=%0d fast=%0d probe=%0d required=0",
                 tick_q.size(), ftick_q.size(), probe_q.size());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    probe = 1'b0; probe_sel = 1'b0; done = 1'b0; final_checked = 1'b0;
    reset_n = 1'b0;
    start = 0; stop = 0; clear = 0; lap = 0; wrap_en = 1'b1;
    f_start = 0; f_stop = 0; f_clear = 0; f_lap = 0; f_wrap = 1'b1;

    cyc(1);
    expect_now("reset_state", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));
    expect_now("reset_state_fast", 1'b1, mk(16'h0, 16'h0, 0, 0, 0, 0));
    reset_n = 1'b1;

    // First increments with TICK_DIV=4, then on through 0x0099 -> 0x0100.
    push_ticks(1'b0, 1, 100);
    start = 1; cyc(1); start = 0;
    expect_now("run_rise", 1'b0, mk(16'h0, 16'h0, 1, 0, 0, 0));
    cyc(3);
    expect_now("pre_first_inc", 1'b0, mk(16'h0, 16'h0, 1, 0, 0, 0));
    cyc(1);
    expect_now("first_inc", 1'b0, mk(16'h0001, 16'h0001, 1, 0, 0, 1));
    cyc(1);
    expect_now("tick_one_cycle", 1'b0, mk(16'h0001, 16'h0001, 1, 0, 0, 0));
    cyc(3);
    expect_now("second_inc", 1'b0, mk(16'h0002, 16'h0002, 1, 0, 0, 1));
    cyc(388);
    expect_now("at_0099", 1'b0, mk(16'h0099, 16'h0099, 1, 0, 0, 1));
    cyc(3);
    expect_now("hold_0099", 1'b0, mk(16'h0099, 16'h0099, 1, 0, 0, 0));
    cyc(1);
    expect_now("ripple_0100", 1'b0, mk(16'h0100, 16'h0100, 1, 0, 0, 1));

    // Pause with prescaler at 2, resume continues mid-period.
    cyc(2);
    stop = 1; cyc(1); stop = 0;
    expect_now("paused", 1'b0, mk(16'h0100, 16'h0100, 0, 0, 0, 0));
    cyc(20);
    expect_now("pause_hold", 1'b0, mk(16'h0100, 16'h0100, 0, 0, 0, 0));
    push_ticks(1'b0, 101, 101);
    start = 1; cyc(1); start = 0;
    expect_now("resume", 1'b0, mk(16'h0100, 16'h0100, 1, 0, 0, 0));
    cyc(1);
    expect_now("resume_plus1", 1'b0, mk(16'h0100, 16'h0100, 1, 0, 0, 0));
    cyc(1);
    expect_now("resume_inc", 1'b0, mk(16'h0101, 16'h0101, 1, 0, 0, 1));
    clear = 1; cyc(1); clear = 0;
    expect_now("clear_run", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));

    // Lap freeze, release, then lap+clear together.
    push_ticks(1'b0, 1, 15);
    start = 1; cyc(1); start = 0;
    cyc(48);
    expect_now("at_0012", 1'b0, mk(16'h0012, 16'h0012, 1, 0, 0, 1));
    lap = 1; cyc(1); lap = 0;
    expect_now("lap_capture", 1'b0, mk(16'h0012, 16'h0012, 1, 1, 0, 0));
    cyc(11);
    expect_now("lap_frozen", 1'b0, mk(16'h0015, 16'h0012, 1, 1, 0, 1));
    lap = 1; cyc(1); lap = 0;
    expect_now("lap_release", 1'b0, mk(16'h0015, 16'h0015, 1, 0, 0, 0));
    lap = 1; clear = 1; cyc(1); lap = 0; clear = 0;
    expect_now("lap_with_clear", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));

    // Async reset mid-count, between clock edges.
    push_ticks(1'b0, 1, 37);
    start = 1; cyc(1); start = 0;
    cyc(148);
    expect_now("at_0037", 1'b0, mk(16'h0037, 16'h0037, 1, 0, 0, 1));
    cyc(1);
    reset_n = 1'b0;
    expect_now("async_reset", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));
    reset_n = 1'b1;

    // clear+stop+start together in RUN lands in IDLE.
    start = 1; cyc(1); start = 0;
    cyc(1);
    clear = 1; stop = 1; start = 1; cyc(1); clear = 0; stop = 0; start = 0;
    expect_now("clear_stop_start", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));
    cyc(8);
    expect_now("idle_hold", 1'b0, mk(16'h0, 16'h0, 0, 0, 0, 0));

    // TICK_DIV=1 instance: wrap at 9999.
    f_wrap = 1'b1;
    push_ticks(1'b1, 1, 9999);
    ftick_q.push_back({1'b1, 16'h0000});
    f_start = 1; cyc(1); f_start = 0;
    cyc(9999);
    expect_now("fast_at_9999", 1'b1, mk(16'h9999, 16'h9999, 1, 0, 0, 1));
    cyc(1);
    expect_now("wrap_to_0", 1'b1, mk(16'h0000, 16'h0000, 1, 0, 1, 1));
    f_clear = 1; cyc(1); f_clear = 0;
    expect_now("fast_clear1", 1'b1, mk(16'h0, 16'h0, 0, 0, 0, 0));

    // Saturate at 9999 and halt in DONE.
    f_wrap = 1'b0;
    push_ticks(1'b1, 1, 9999);
    f_start = 1; cyc(1); f_start = 0;
    cyc(10000);
    expect_now("saturate", 1'b1, mk(16'h9999, 16'h9999, 0, 0, 1, 0));
    cyc(1);
    expect_now("done_hold", 1'b1, mk(16'h9999, 16'h9999, 0, 0, 1, 0));
    f_start = 1; cyc(1); f_start = 0;
    expect_now("done_ignores_start", 1'b1, mk(16'h9999, 16'h9999, 0, 0, 1, 0));
    f_lap = 1; cyc(1); f_lap = 0;
    expect_now("done_ignores_lap", 1'b1, mk(16'h9999, 16'h9999, 0, 0, 1, 0));
    f_clear = 1; cyc(1); f_clear = 0;
    expect_now("done_clear", 1'b1, mk(16'h0, 16'h0, 0, 0, 0, 0));

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
